// File: rtl/penc_pkg.sv
// Shared helpers for the pending priority encoder.
// Contents: index-width helper, one-hot decoder, and the round-robin
// pointer reset value. The pointer is only used when PENC_ROUND_ROBIN_EN
// is defined.
package penc_pkg;

  localparam int unsigned PENC_MAX_N = 64;
  localparam int unsigned PENC_MAX_W = 6;

  // Index width for an N-line encoder (never less than 1 bit).
  function automatic int unsigned penc_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Reset value of the round-robin pointer, so the first search starts at the top line.
  function automatic int unsigned ptr_rst_val(input int unsigned n);
    return n - 1;
  endfunction

  // One-hot decode at the widest legal size; callers truncate to N bits.
  function automatic logic [PENC_MAX_N-1:0] onehot(input logic [PENC_MAX_W-1:0] idx);
    return PENC_MAX_N'(1) << idx;
  endfunction

endpackage

// File: rtl/pending_priority_encoder_prio_pick.sv
// prio_pick: combinational find-first-set, searching downward from 'start'
// with wrap-around (start, start-1, ..., 0, N-1, ...).
// Ports:
//   vec   - candidate vector
//   start - first index examined
//   sel   - first set index found in search order (0 when none)
//   found - vec has at least one set bit
module prio_pick
  import penc_pkg::*;
#(
  parameter  int unsigned N = 8,
  localparam int unsigned W = penc_width(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic [W-1:0] sel,
  output logic         found
);

  int unsigned pos;
  logic [W-1:0] pos_w;

  // Walk the search order; the first set bit closest to 'start' wins.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    pos   = 0;
    pos_w = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pos   = (32'(start) + N - i) % N;
      pos_w = W'(pos);
      if (!found && vec[pos_w]) begin
        sel   = pos_w;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pending_priority_encoder.sv
// pending_priority_encoder: latches N request lines into a pending register
// and issues one selected, unmasked pending index at a time on a
// valid/ready output. Fixed priority (highest index wins) by default;
// defining PENC_ROUND_ROBIN_EN adds a rotating search pointer so no
// unmasked line can starve.
// Ports:
//   clk       - system clock, rising edge
//   rst       - synchronous active-high reset
//   req[N]    - per-line event pulse
//   mask[N]   - per-line issue enable (masked lines stay pending)
//   out_valid - out_idx holds an issued, unaccepted index
//   out_ready - downstream accepts out_idx when out_valid=1
//   out_idx   - issued line index
//   pending   - pending vector, issued entry excluded
//   overflow  - one-cycle pulse: an event merged into an already-pending line
module pending_priority_encoder
  import penc_pkg::*;
#(
  parameter  int unsigned N = 8,
  localparam int unsigned W = penc_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pending,
  output logic         overflow
);

  logic [N-1:0] cand_c;
  logic [N-1:0] clr_c;
  logic [W-1:0] start_c;
  logic [W-1:0] sel_c;
  logic         found_c;
  logic         load_c;

  assign cand_c = (pending | req) & mask;

`ifdef PENC_ROUND_ROBIN_EN
  logic [W-1:0] ptr;

  assign start_c = ptr;

  // Next search starts just below the line issued last, wrapping to the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= W'(ptr_rst_val(N));
    end else if (load_c) begin
      ptr <= (sel_c == '0) ? W'(ptr_rst_val(N)) : W'(sel_c - W'(1));
    end
  end
`else
  assign start_c = W'(ptr_rst_val(N));
`endif

  prio_pick #(.N(N)) u_pick (
    .vec   (cand_c),
    .start (start_c),
    .sel   (sel_c),
    .found (found_c)
  );

  // A new index may be issued whenever the output register is free or being drained.
  assign load_c = (!out_valid || out_ready) && found_c;
  assign clr_c  = load_c ? N'(onehot(PENC_MAX_W'(sel_c))) : '0;

  // Pending, output register and overflow pulse.
  // A req on the line being issued this cycle is consumed by the issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      overflow  <= 1'b0;
    end else begin
      pending  <= (pending | req) & ~clr_c;
      overflow <= |(req & pending);
      if (load_c) begin
        out_valid <= 1'b1;
        out_idx   <= sel_c;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pending_priority_encoder.sv
// Directed self-checking bench for pending_priority_encoder (N=8).
// Expected values are hand-computed; the round-robin case has separate
// expectations when PENC_ROUND_ROBIN_EN is defined.
module tb_pending_priority_encoder;

  localparam int unsigned N = 8;
  localparam int unsigned W = 3;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] mask;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic [N-1:0] pending;
  logic         overflow;

  int checks;
  int errors;

  pending_priority_encoder #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mask      (mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .pending   (pending),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    req       = '0;
    mask      = 8'hFF;
    out_ready = 1'b1;

    // Reset then idle
    tick();
    tick();
    check("rst_pending", 64'(pending), 64'h00);
    check("rst_valid", 64'(out_valid), 64'h0);
    check("rst_idx", 64'(out_idx), 64'h0);
    check("rst_ovf", 64'(overflow), 64'h0);
    rst = 1'b0;
    tick();
    check("idle_valid", 64'(out_valid), 64'h0);

    // Fixed priority order: 5, 2, 1
    do_reset();
    req = 8'b0010_0110;
    tick();
    req = '0;
    check("prio_idx0", 64'(out_idx), 64'd5);
    check("prio_valid0", 64'(out_valid), 64'h1);
    check("prio_pend0", 64'(pending), 64'h06);
    tick();
    check("prio_idx1", 64'(out_idx), 64'd2);
    check("prio_pend1", 64'(pending), 64'h02);
    tick();
    check("prio_idx2", 64'(out_idx), 64'd1);
    check("prio_pend2", 64'(pending), 64'h00);
    tick();
    check("prio_drain_valid", 64'(out_valid), 64'h0);
    check("prio_drain_idx", 64'(out_idx), 64'd1);

    // Backpressure holds the issued index stable
    do_reset();
    out_ready = 1'b0;
    req = 8'h81;
    tick();
    req = '0;
    check("bp_idx", 64'(out_idx), 64'd7);
    check("bp_pend", 64'(pending), 64'h01);
    tick();
    check("bp_hold_idx", 64'(out_idx), 64'd7);
    check("bp_hold_valid", 64'(out_valid), 64'h1);
    out_ready = 1'b1;
    tick();
    check("bp_next_idx", 64'(out_idx), 64'd0);
    check("bp_next_pend", 64'(pending), 64'h00);
    tick();
    check("bp_drain_valid", 64'(out_valid), 64'h0);

    // Overflow on a masked, pending line
    do_reset();
    mask = 8'hF7;
    req = 8'h08;
    tick();
    check("ovf_pend_first", 64'(pending), 64'h08);
    check("ovf_none_first", 64'(overflow), 64'h0);
    check("ovf_masked_valid", 64'(out_valid), 64'h0);
    tick();
    req = '0;
    check("ovf_pulse", 64'(overflow), 64'h1);
    check("ovf_pend_merged", 64'(pending), 64'h08);
    tick();
    check("ovf_pulse_end", 64'(overflow), 64'h0);
    mask = 8'hFF;
    tick();
    check("ovf_issue_idx", 64'(out_idx), 64'd3);
    check("ovf_issue_valid", 64'(out_valid), 64'h1);
    check("ovf_issue_pend", 64'(pending), 64'h00);
    tick();
    check("ovf_single_issue", 64'(out_valid), 64'h0);

    // A req on the held line is a new event, not overflow
    do_reset();
    out_ready = 1'b0;
    req = 8'h04;
    tick();
    check("held_idx", 64'(out_idx), 64'd2);
    check("held_pend0", 64'(pending), 64'h00);
    tick();
    req = '0;
    check("held_new_pend", 64'(pending), 64'h04);
    check("held_new_ovf", 64'(overflow), 64'h0);
    check("held_still_idx", 64'(out_idx), 64'd2);
    out_ready = 1'b1;
    tick();
    check("held_reissue_idx", 64'(out_idx), 64'd2);
    check("held_reissue_valid", 64'(out_valid), 64'h1);
    check("held_reissue_pend", 64'(pending), 64'h00);

    // req on the selected line in the load cycle is consumed by the issue
    do_reset();
    req = 8'h10;
    tick();
    check("cons_idx0", 64'(out_idx), 64'd4);
    tick();
    req = '0;
    check("cons_idx1", 64'(out_idx), 64'd4);
    check("cons_valid1", 64'(out_valid), 64'h1);
    check("cons_pend", 64'(pending), 64'h00);
    check("cons_ovf", 64'(overflow), 64'h0);
    tick();
    check("cons_drain", 64'(out_valid), 64'h0);

    // Reset mid-operation discards everything
    do_reset();
    out_ready = 1'b0;
    req = 8'h1C;
    tick();
    req = '0;
    check("midrst_pre_idx", 64'(out_idx), 64'd4);
    check("midrst_pre_pend", 64'(pending), 64'h0C);
    rst = 1'b1;
    req = 8'hFF;
    tick();
    rst = 1'b0;
    req = '0;
    check("midrst_pend", 64'(pending), 64'h00);
    check("midrst_valid", 64'(out_valid), 64'h0);
    check("midrst_idx", 64'(out_idx), 64'h0);
    check("midrst_ovf", 64'(overflow), 64'h0);
    out_ready = 1'b1;
    tick();
    check("midrst_no_issue", 64'(out_valid), 64'h0);

    // Mask change does not disturb an issued index
    do_reset();
    out_ready = 1'b0;
    req = 8'h21;
    tick();
    req = '0;
    check("mask_idx", 64'(out_idx), 64'd5);
    mask = 8'h00;
    tick();
    check("mask_hold_idx", 64'(out_idx), 64'd5);
    check("mask_hold_valid", 64'(out_valid), 64'h1);
    out_ready = 1'b1;
    tick();
    check("mask_accept_valid", 64'(out_valid), 64'h0);
    check("mask_accum_pend", 64'(pending), 64'h01);
    mask = 8'hFF;
    tick();
    check("mask_unmask_idx", 64'(out_idx), 64'd0);
    check("mask_unmask_valid", 64'(out_valid), 64'h1);

    // Continuous req=8'h88 with out_ready high
    do_reset();
    req = 8'h88;
    tick();
    check("rr_idx0", 64'(out_idx), 64'd7);
    tick();
`ifdef PENC_ROUND_ROBIN_EN
    check("rr_idx1", 64'(out_idx), 64'd3);
`else
    check("rr_idx1", 64'(out_idx), 64'd7);
`endif
    tick();
    check("rr_idx2", 64'(out_idx), 64'd7);
    tick();
    req = '0;
`ifdef PENC_ROUND_ROBIN_EN
    check("rr_idx3", 64'(out_idx), 64'd3);
    check("rr_pend3", 64'(pending), 64'h80);
`else
    check("rr_idx3", 64'(out_idx), 64'd7);
    check("rr_pend3", 64'(pending), 64'h08);
`endif
    tick();
`ifdef PENC_ROUND_ROBIN_EN
    check("rr_tail_idx", 64'(out_idx), 64'd7);
`else
    check("rr_tail_idx", 64'(out_idx), 64'd3);
`endif
    tick();
    check("rr_tail_drain", 64'(out_valid), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
